// File: rtl/bcd_to_binary_pkg.sv
// Shared types and constants for the packed-BCD to binary converter.
// Holds the FSM state encoding and the per-digit correction thresholds.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [3:0] BCD_DIGIT_MAX  = 4'd9;
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
    localparam logic [3:0] BCD_ADJ_VAL    = 4'd3;

    function automatic logic digit_is_valid(input logic [3:0] digit);
        return digit <= BCD_DIGIT_MAX;
    endfunction

endpackage

// File: rtl/bcd_to_binary_if.sv
// Request/response bundle between a keypad operand source and the converter.
// The master issues start/bcd_in; the slave (converter) returns status and result.
interface bcd_to_binary_if #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [BIN_W-1:0]      binary_out;

    modport master (
        output start, bcd_in,
        input  busy, done, err, binary_out
    );

    modport slave (
        input  start, bcd_in,
        output busy, done, err, binary_out
    );
endinterface

// File: rtl/bcd_digit_adjust.sv
// One-digit correction for reverse double-dabble: a digit that received a
// shifted-in 8 from its upper neighbour is really worth 5, so take 3 back.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);
    assign o_nib = (i_nib >= BCD_ADJ_THRESH) ? (i_nib - BCD_ADJ_VAL) : i_nib;
endmodule

// File: rtl/bcd_to_binary.sv
// Multi-cycle packed-BCD to unsigned binary converter, one bit per clock.
// Malformed digits are reported via err with a single-cycle done pulse.
module bcd_to_binary
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
)(
    input  logic              clk,
    input  logic              rst,
    bcd_to_binary_if.slave    bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    state_t             r_state, w_state_nxt;
    logic [SR_W-1:0]    r_sr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy, r_done, r_err, r_err_pend;
    logic [BIN_W-1:0]   r_bin;

    logic [SR_W-1:0]    w_sr_shift, w_sr_adj;
    logic               w_bcd_ok, w_accept, w_reject;

    always_comb begin
        w_bcd_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!digit_is_valid(bus.bcd_in[4*i +: 4])) w_bcd_ok = 1'b0;
        end
    end

    // An invalid request is reported one edge later, so the cycle in between
    // is spent in IDLE with r_err_pend set and no new request is taken.
    assign w_accept = (r_state == IDLE) && bus.start && w_bcd_ok && !r_err_pend;
    assign w_reject = (r_state == IDLE) && bus.start && !w_bcd_ok && !r_err_pend;

    assign w_sr_shift = r_sr >> 1;
    assign w_sr_adj[BIN_W-1:0] = w_sr_shift[BIN_W-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .i_nib (w_sr_shift[BIN_W + 4*g +: 4]),
            .o_nib (w_sr_adj[BIN_W + 4*g +: 4])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // NOTE: defaulting w_state_nxt before the case keeps every path assigned, so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_state_nxt = SHIFT;
            SHIFT:   if (r_cnt == CNT_W'(BIN_W - 1)) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments make every register here update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr       <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_pend <= 1'b0;
            r_bin      <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (r_err_pend) begin
                        r_err_pend <= 1'b0;
                        r_done     <= 1'b1;
                        r_err      <= 1'b1;
                        r_bin      <= '0;
                    end else if (w_accept) begin
                        r_sr   <= {bus.bcd_in, {BIN_W{1'b0}}};
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                    end else if (w_reject) begin
                        r_err_pend <= 1'b1;
                    end
                end
                SHIFT: begin
                    r_sr  <= w_sr_adj;
                    r_cnt <= r_cnt + 1'b1;
                end
                DONE: begin
                    r_bin  <= r_sr[BIN_W-1:0];
                    r_err  <= 1'b0;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.err        = r_err;
    assign bus.binary_out = r_bin;
endmodule
